// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive bit-timing scheduler.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    localparam int OVS_DEF       = 16;
    localparam int DATA_BITS_DEF = 8;
    localparam int MID           = OVS_DEF / 2;
    localparam int BIT_CNT_W     = 3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sched_tick.sv
// Oversample tick-enable: DIV_W down-counter reloading from a divisor that is
// captured only while load_en is high.
module uart_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else begin
            if (load_en)
                div_q <= divisor;
            cnt <= (cnt == '0) ? div_q : cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_sched.sv
// UART receive bit-timing scheduler on sys_clk with a single oversample tick.
// Define UART_RX_MAJORITY_EN to sample by 3-tick majority vote around mid-bit.
module uart_rx_sched
    import uart_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int OVS       = OVS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] divisor,
    input  logic             rx,
    output logic             sample_stb,
    output logic             sample_bit,
    output logic [2:0]       bit_idx,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic             false_start
);

    localparam int OS_W  = $clog2(OVS);
    localparam int HALF  = OVS / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int SP    = HALF + 1;
`else
    localparam int SP    = HALF;
`endif
    localparam logic [OS_W-1:0]      OS_SP    = OS_W'(SP);
    localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVS - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

    state_t               state, state_n;
    logic [OS_W-1:0]      os_cnt, os_n;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_n;
    logic                 rx_meta, rx_s;
    logic                 tick, samp, at_sp, at_last;
    logic                 stb_n, done_n, err_n, fs_n, sbit_n;
    logic [2:0]           idx_n;

    uart_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk     (sys_clk),
        .rst     (rst),
        .load_en (state == IDLE),
        .divisor (divisor),
        .tick    (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic vote_a, vote_b;

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (tick) begin
            if (os_cnt == OS_W'(HALF - 1)) vote_a <= rx_s;
            if (os_cnt == OS_W'(HALF))     vote_b <= rx_s;
        end
    end

    assign samp = maj3(vote_a, vote_b, rx_s);
`else
    assign samp = rx_s;
`endif

    assign at_sp   = (os_cnt == OS_SP);
    assign at_last = (os_cnt == OS_LAST);
    assign busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        os_n    = os_cnt;
        bit_n   = bit_cnt;
        stb_n   = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        fs_n    = 1'b0;
        sbit_n  = sample_bit;
        idx_n   = bit_idx;
        if (!enable) begin
            state_n = IDLE;
            os_n    = '0;
            bit_n   = '0;
            sbit_n  = 1'b0;
            idx_n   = '0;
        end else if (tick) begin
            // The start-edge tick is tick 0 of the start bit.
            os_n = at_last ? '0 : os_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (!rx_s) state_n = START;
                    else       os_n    = '0;
                end
                START: begin
                    if (at_sp && samp) begin
                        fs_n    = 1'b1;
                        state_n = IDLE;
                        os_n    = '0;
                    end else if (at_last) begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                end
                DATA: begin
                    if (at_sp) begin
                        stb_n  = 1'b1;
                        sbit_n = samp;
                        idx_n  = bit_cnt;
                    end
                    if (at_last) begin
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                            bit_n   = '0;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (at_sp) begin
                        if (samp) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                            os_n    = '0;
                        end else begin
                            err_n   = 1'b1;
                            state_n = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_n = IDLE;
                        os_n    = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    os_n    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state       <= IDLE;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            sample_stb  <= 1'b0;
            sample_bit  <= 1'b0;
            bit_idx     <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            false_start <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            state       <= state_n;
            os_cnt      <= os_n;
            bit_cnt     <= bit_n;
            sample_stb  <= stb_n;
            sample_bit  <= sbit_n;
            bit_idx     <= idx_n;
            frame_done  <= done_n;
            frame_err   <= err_n;
            false_start <= fs_n;
        end
    end

endmodule

// File: tb/tb_uart_rx_sched.sv
// Scoreboard bench for uart_rx_sched: frames are expanded into expected pulse
// events from the byte value, and a negedge monitor pops and compares them.
module tb_uart_rx_sched;

    localparam int DIV     = 3;
    localparam int OVS     = 16;
    localparam int BIT_CYC = (DIV + 1) * OVS;
`ifdef UART_RX_MAJORITY_EN
    localparam int  MAJ_SHIFT = 4;
    localparam logic GLITCH_B3 = 1'b1;
`else
    localparam int  MAJ_SHIFT = 0;
    localparam logic GLITCH_B3 = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] divisor = 16'(DIV);
    logic        rx_drv = 1'b1;
    logic        glitch_n = 1'b1;
    logic        rx;
    logic        sample_stb, sample_bit, busy, frame_done, frame_err, false_start;
    logic [2:0]  bit_idx;

    assign rx = rx_drv & glitch_n;

    uart_rx_sched #(.DIV_W(16), .OVS(OVS), .DATA_BITS(8)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .enable      (enable),
        .divisor     (divisor),
        .rx          (rx),
        .sample_stb  (sample_stb),
        .sample_bit  (sample_bit),
        .bit_idx     (bit_idx),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .false_start (false_start)
    );

    always #5 sys_clk = ~sys_clk;

    typedef enum int {EV_STB = 0, EV_DONE = 1, EV_ERR = 2, EV_FS = 3} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        logic     bit_v;
        int       idx;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  t_start = 0;
    int  last_done_cyc = -1;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push_ev(input ev_kind_t k, input logic v, input int i);
        ev_t e;
        e.kind  = k;
        e.bit_v = v;
        e.idx   = i;
        exp_q.push_back(e);
    endfunction

    function automatic void push_frame(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 8; i++) push_ev(EV_STB, b[i], i);
        push_ev(stop ? EV_DONE : EV_ERR, 1'b0, 0);
    endfunction

    // Monitor: every presented pulse consumes one expected event.
    always @(negedge sys_clk) begin
        int   npulse;
        int   act_kind;
        ev_t  e;
        npulse = int'(sample_stb) + int'(frame_done) + int'(frame_err) + int'(false_start);
        if (npulse > 1) check("single_pulse_per_cycle", npulse, 1);
        if (npulse >= 1) begin
            act_kind = sample_stb ? 0 : frame_done ? 1 : frame_err ? 2 : 3;
            if (frame_done) last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_kind", act_kind, -1);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", act_kind, int'(e.kind));
                if (e.kind == EV_STB) begin
                    check("sample_bit", int'(sample_bit), int'(e.bit_v));
                    check("bit_idx", int'(bit_idx), e.idx);
                end
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx_drv = v;
        repeat (BIT_CYC) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx_drv = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_drv = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_stb"}, int'(sample_stb), 0);
        check({tag, "_done"}, int'(frame_done), 0);
        check({tag, "_err"}, int'(frame_err), 0);
        check({tag, "_fs"}, int'(false_start), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic prev;
        logic [7:0] b;
        logic st;

        // Reset state
        repeat (4) @(negedge sys_clk);
        check_quiet("reset");
        check("reset_sample_bit", int'(sample_bit), 0);
        check("reset_bit_idx", int'(bit_idx), 0);
        rst = 1'b1;
        idle(2 * BIT_CYC);

        // 0xA5 with good stop; frame_done lands 608 cycles after the start
        // edge, plus synchroniser, tick phase and output register latency.
        push_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1);
        idle(BIT_CYC);
        check("a5_done_latency_in_window",
              int'((last_done_cyc - t_start) >= 604 && (last_done_cyc - t_start) <= 616), 1);
        check("a5_queue_drained", exp_q.size(), 0);

        // False start: 3 ticks low
        push_ev(EV_FS, 1'b0, 0);
        rx_drv = 1'b0;
        repeat (12) @(negedge sys_clk);
        rx_drv = 1'b1;
        found = 0;
        prev = busy;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge sys_clk);
            if (false_start) begin
                found = 1;
                check("fs_busy_with_pulse", int'(busy), 0);
                check("fs_busy_before_pulse", int'(prev), 1);
            end
            prev = busy;
        end
        check("fs_seen", int'(found), 1);
        idle(BIT_CYC);

        // 0x3C with bad stop, then a held break
        push_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0);
        rx_drv = 1'b0;
        repeat (200) @(negedge sys_clk);
        check("break_busy_held", int'(busy), 1);
        rx_drv = 1'b1;
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge sys_clk);
            if (!busy) found = 1;
        end
        check("break_released", int'(found), 1);
        idle(BIT_CYC);

        // Back-to-back frames
        push_frame(8'h00, 1'b1);
        push_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(BIT_CYC);
        check("b2b_queue_drained", exp_q.size(), 0);

        // Reset during data bit 4: only bits 0..3 may strobe
        b = 8'h96;
        for (int i = 0; i < 4; i++) push_ev(EV_STB, b[i], i);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_drv = b[4];
        repeat (16) @(negedge sys_clk);
        rst = 1'b0;
        rx_drv = 1'b1;
        @(negedge sys_clk);
        check_quiet("midreset");
        check("midreset_bit_idx", int'(bit_idx), 0);
        rst = 1'b1;
        idle(3 * BIT_CYC);
        check("midreset_queue_drained", exp_q.size(), 0);
        push_frame(8'h55, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(BIT_CYC);

        // Enable dropped during data bit 1: only bit 0 strobes
        b = 8'h5A;
        push_ev(EV_STB, b[0], 0);
        drive_bit(1'b0);
        drive_bit(b[0]);
        rx_drv = b[1];
        repeat (2) @(negedge sys_clk);
        enable = 1'b0;
        @(negedge sys_clk);
        check_quiet("disable");
        repeat (BIT_CYC - 3) @(negedge sys_clk);
        for (int i = 2; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b1);
        idle(BIT_CYC);
        enable = 1'b1;
        idle(BIT_CYC);
        check("disable_queue_drained", exp_q.size(), 0);

        // One-tick low glitch at mid of bit 3 of 0xFF, aligned to the bit-2 strobe
        for (int i = 0; i < 8; i++) push_ev(EV_STB, (i == 3) ? GLITCH_B3 : 1'b1, i);
        push_ev(EV_DONE, 1'b0, 0);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                bit seen;
                seen = 0;
                for (int k = 0; k < 1000 && !seen; k++) begin
                    @(negedge sys_clk);
                    if (sample_stb && bit_idx == 3'd2) seen = 1;
                end
                check("glitch_ref_strobe_seen", int'(seen), 1);
                if (seen) begin
                    repeat (59 - MAJ_SHIFT) @(negedge sys_clk);
                    glitch_n = 1'b0;
                    repeat (4) @(negedge sys_clk);
                    glitch_n = 1'b1;
                end
            end
        join
        idle(BIT_CYC);

        // Randomised frames and false starts
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                push_ev(EV_FS, 1'b0, 0);
                rx_drv = 1'b0;
                repeat ($urandom_range(4, 16)) @(negedge sys_clk);
                idle(BIT_CYC);
            end
            b  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 4) != 0);
            push_frame(b, st);
            send_frame(b, st);
            if (!st || $urandom_range(0, 1) == 1) idle(BIT_CYC);
        end
        idle(2 * BIT_CYC);
        check("final_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
